digit_serial_add_sub: RTL and testbench

Parametrised, multi-cycle N-bit adder/subtractor that processes D bits per clock, LSB digit first.
- Operands are accepted through a valid/ready input handshake.
- Result is presented through a valid/ready output handshake, with carry/borrow and signed-overflow flags.
- Trades latency for area against the combinational ripple adder/subtractor.
- Used where a wide arithmetic result is not timing-critical.

---
 rtl/digit_serial_add_sub.sv | 150 +++++++++++++++
 tb/tb_digit_serial_add_sub.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_add_sub
// Function : N-bit adder/subtractor that works D bits per clock, LSB digit
//            first, behind valid/ready handshakes on both sides.
// Revision : 1.0
// ============================================================================
module digit_serial_add_sub #(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         add_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         ovf
);

    localparam int NDIG  = N / D;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_param_check
        $fatal(1, "digit_serial_add_sub: need N >= 2, 1 <= D <= N and N %% D == 0");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_last;

    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_res;
    logic [N-1:0]     r_s;
    logic             r_carry;
    logic             r_add_sub;
    logic             r_c_out;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic [D:0]       w_dsum;
    logic [N-1:0]     w_res_nxt;
    logic             w_cin_msb;

    assign w_dsum = {1'b0, r_a[D-1:0]} + {1'b0, r_b[D-1:0]} + {{D{1'b0}}, r_carry};

    // Carry into the digit's top bit recovered from the sum bit: s = a ^ b ^ cin.
    assign w_cin_msb = r_a[D-1] ^ r_b[D-1] ^ w_dsum[D-1];

    assign w_last = (r_cnt == CNT_W'(NDIG - 1));

    if (D == N) begin : g_full
        assign w_res_nxt = w_dsum[D-1:0];
    end else begin : g_part
        assign w_res_nxt = {w_dsum[D-1:0], r_res[N-1:D]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_accept   = in_valid;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_s       <= '0;
            r_carry   <= 1'b0;
            r_add_sub <= 1'b0;
            r_c_out   <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            // Subtraction as A + ~B + 1: invert B here, seed the carry with 1.
            r_a       <= a;
            r_b       <= b ^ {N{add_sub}};
            r_add_sub <= add_sub;
            r_carry   <= add_sub;
            r_cnt     <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> D;
            r_b     <= r_b >> D;
            r_res   <= w_res_nxt;
            r_carry <= w_dsum[D];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_s     <= w_res_nxt;
                r_c_out <= r_add_sub ^ w_dsum[D];
                r_ovf   <= w_cin_msb ^ w_dsum[D];
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign s         = r_s;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_add_sub
// Function : Randomised self-checking bench for digit_serial_add_sub across
//            (N,D) = (8,2), (8,1), (8,8), (12,3) against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_digit_serial_add_sub;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid_v;
    logic [3:0]  out_ready_v;
    logic [3:0]  add_sub_v;
    logic [11:0] a_v [4];
    logic [11:0] b_v [4];
    wire  [3:0]  in_ready_v;
    wire  [3:0]  out_valid_v;
    wire  [3:0]  c_out_v;
    wire  [3:0]  ovf_v;
    wire  [3:0][11:0] s_v;

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int NN = (k == 3) ? 12 : 8;
        localparam int DD = (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 8 : 3;
        wire [NN-1:0] w_s;
        digit_serial_add_sub #(.N(NN), .D(DD)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[k]),
            .in_ready  (in_ready_v[k]),
            .a         (a_v[k][NN-1:0]),
            .b         (b_v[k][NN-1:0]),
            .add_sub   (add_sub_v[k]),
            .out_valid (out_valid_v[k]),
            .out_ready (out_ready_v[k]),
            .s         (w_s),
            .c_out     (c_out_v[k]),
            .ovf       (ovf_v[k])
        );
        assign s_v[k] = 12'(w_s);
    end

    function automatic int n_of(input int k);
        return (k == 3) ? 12 : 8;
    endfunction

    function automatic int d_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 8 : 3;
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    task automatic ref_calc(input int n, input logic [11:0] av, input logic [11:0] bv,
                            input logic sub, output logic [11:0] es,
                            output logic ec, output logic eo);
        longint ua, ub, full, sa, sb, r, mx, mn;
        ua = longint'(av) & ((64'sd1 << n) - 1);
        ub = longint'(bv) & ((64'sd1 << n) - 1);
        full = sub ? (ua - ub) : (ua + ub);
        es = 12'(full & ((64'sd1 << n) - 1));
        ec = sub ? (ua < ub) : (full >= (64'sd1 << n));
        sa = (ua >= (64'sd1 << (n - 1))) ? ua - (64'sd1 << n) : ua;
        sb = (ub >= (64'sd1 << (n - 1))) ? ub - (64'sd1 << n) : ub;
        r  = sub ? (sa - sb) : (sa + sb);
        mx = (64'sd1 << (n - 1)) - 1;
        mn = -(64'sd1 << (n - 1));
        eo = (r > mx) || (r < mn);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, hold the result `hold` cycles, then consume it.
    // lat is the accept-to-out_valid edge count, or -1 if a bound expired.
    task automatic run_op(input int k, input logic [11:0] av, input logic [11:0] bv,
                          input logic sub, input int hold,
                          output logic [11:0] so, output logic co, output logic oo,
                          output int lat);
        int w;
        w = 0;
        while (!in_ready_v[k] && w < 50) begin
            step();
            w++;
        end
        so = 'x; co = 1'bx; oo = 1'bx;
        if (!in_ready_v[k]) begin
            lat = -1;
            return;
        end
        a_v[k] = av;
        b_v[k] = bv;
        add_sub_v[k] = sub;
        in_valid_v[k] = 1'b1;
        out_ready_v[k] = 1'b0;
        step();
        in_valid_v[k] = 1'b0;
        a_v[k] = 12'($urandom);
        b_v[k] = 12'($urandom);
        add_sub_v[k] = 1'($urandom);
        lat = 0;
        while (!out_valid_v[k] && lat < 100) begin
            step();
            lat++;
        end
        if (!out_valid_v[k]) begin
            lat = -1;
            return;
        end
        for (int i = 0; i < hold; i++) step();
        so = s_v[k];
        co = c_out_v[k];
        oo = ovf_v[k];
        out_ready_v[k] = 1'b1;
        step();
        out_ready_v[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (in_ready_v[k] !== 1'b1 || out_valid_v[k] !== 1'b0 || s_v[k] !== 12'h0 ||
                c_out_v[k] !== 1'b0 || ovf_v[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b s=%h c=%b ovf=%b, required 1 0 000 0 0",
                         k, in_ready_v[k], out_valid_v[k], s_v[k], c_out_v[k], ovf_v[k]);
            end
        end
    endtask

    task automatic test_directed();
        logic [11:0] av [6] = '{12'h5A, 12'hFF, 12'h10, 12'h80, 12'h33, 12'h7F};
        logic [11:0] bv [6] = '{12'h3C, 12'h01, 12'h20, 12'h01, 12'h33, 12'h80};
        logic        sb [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [11:0] xs [6] = '{12'h96, 12'h00, 12'hF0, 12'h7F, 12'h00, 12'hFF};
        logic        xc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        xo [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [11:0] so;
        logic co, oo;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(0, av[i], bv[i], sb[i], 0, so, co, oo, lat);
            n_checks++;
            if (lat !== 4) begin
                n_errors++;
                $display("FAIL directed_latency op%0d: got %0d cycles, required 4", i, lat);
            end
            n_checks++;
            if ({co, oo, so} !== {xc[i], xo[i], xs[i]}) begin
                n_errors++;
                $display("FAIL directed_result op%0d %h%s%h: got s=%h c=%b ovf=%b, required s=%h c=%b ovf=%b",
                         i, av[i], sb[i] ? "-" : "+", bv[i], so, co, oo, xs[i], xc[i], xo[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int w;
        a_v[0] = 12'h5A; b_v[0] = 12'h3C; add_sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        out_ready_v[0] = 1'b0;
        step();
        in_valid_v[0] = 1'b0;
        w = 0;
        while (!out_valid_v[0] && w < 20) begin
            step();
            w++;
        end
        a_v[0] = 12'h01; b_v[0] = 12'h02; add_sub_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 ||
                s_v[0] !== 12'h96 || c_out_v[0] !== 1'b0 || ovf_v[0] !== 1'b1) begin
                n_errors++;
                $display("FAIL backpressure_hold cyc%0d: out_valid=%b in_ready=%b s=%h c=%b ovf=%b, required 1 0 096 0 1",
                         c, out_valid_v[0], in_ready_v[0], s_v[0], c_out_v[0], ovf_v[0]);
            end
            step();
        end
        out_ready_v[0] = 1'b1;
        n_checks++;
        if (s_v[0] !== 12'h96 || out_valid_v[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure_deliver: s=%h out_valid=%b, required 096 1", s_v[0], out_valid_v[0]);
        end
        step();
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b0;
        n_checks++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || s_v[0] !== 12'h96 ||
            c_out_v[0] !== 1'b0 || ovf_v[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure_idle_keep: in_ready=%b out_valid=%b s=%h c=%b ovf=%b, required 1 0 096 0 1",
                     in_ready_v[0], out_valid_v[0], s_v[0], c_out_v[0], ovf_v[0]);
        end
        step();
        n_checks++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure_no_queue: in_ready=%b out_valid=%b, required 1 0",
                     in_ready_v[0], out_valid_v[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [11:0] so;
        logic co, oo;
        int lat;
        a_v[0] = 12'hA7; b_v[0] = 12'h6E; add_sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        step();
        in_valid_v[0] = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || s_v[0] !== 12'h0 ||
            c_out_v[0] !== 1'b0 || ovf_v[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_run: in_ready=%b out_valid=%b s=%h c=%b ovf=%b, required 1 0 000 0 0",
                     in_ready_v[0], out_valid_v[0], s_v[0], c_out_v[0], ovf_v[0]);
        end
        step();
        n_checks++;
        if (out_valid_v[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_no_result: out_valid=%b, required 0", out_valid_v[0]);
        end
        run_op(0, 12'h01, 12'h01, 1'b0, 0, so, co, oo, lat);
        n_checks++;
        if (so !== 12'h02 || co !== 1'b0 || oo !== 1'b0 || lat !== 4) begin
            n_errors++;
            $display("FAIL reset_fresh_op: s=%h c=%b ovf=%b lat=%0d, required 002 0 0 4", so, co, oo, lat);
        end
    endtask

    task automatic test_random(input int k, input int nops);
        logic [11:0] av, bv, so, es;
        logic sub, co, oo, ec, eo;
        int lat, n, errs_before;
        n = n_of(k);
        errs_before = n_errors;
        for (int i = 0; i < nops; i++) begin
            av  = 12'($urandom);
            bv  = 12'($urandom);
            case ($urandom_range(0, 7))
                0: av = '0;
                1: bv = '1;
                2: bv = av;
                default: ;
            endcase
            av  = av & 12'((1 << n) - 1);
            bv  = bv & 12'((1 << n) - 1);
            sub = 1'($urandom);
            ref_calc(n, av, bv, sub, es, ec, eo);
            run_op(k, av, bv, sub, int'($urandom_range(0, 3)), so, co, oo, lat);
            n_checks++;
            if (lat !== n / d_of(k)) begin
                n_errors++;
                $display("FAIL random_latency N=%0d D=%0d op%0d: got %0d, required %0d",
                         n, d_of(k), i, lat, n / d_of(k));
            end
            n_checks++;
            if ({co, oo, so} !== {ec, eo, es}) begin
                n_errors++;
                $display("FAIL random_result N=%0d D=%0d op%0d %h%s%h: got s=%h c=%b ovf=%b, required s=%h c=%b ovf=%b",
                         n, d_of(k), i, av, sub ? "-" : "+", bv, so, co, oo, es, ec, eo);
            end
            if (n_errors - errs_before > 20) break;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        in_valid_v = '0;
        out_ready_v = '0;
        add_sub_v = '0;
        for (int k = 0; k < 4; k++) begin
            a_v[k] = '0;
            b_v[k] = '0;
        end
        step();
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random(0, 200);
        test_random(1, 500);
        test_random(2, 500);
        test_random(3, 500);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
